// File: rtl/clk_div_pkg.sv
// Shared constants and ratio helpers for the multi-channel clock divider.
// Latency: none (pure functions).
// Backpressure: none.
package clk_div_pkg;

    // Default ratio width; channels and top may override via parameter.
    localparam int DIV_W_DEF = 8;

    // A programmed ratio of 0 behaves as divide-by-1.
    function automatic int unsigned eff_div(input int unsigned n);
        return (n == 0) ? 32'd1 : n;
    endfunction

    // Number of high cycles in one period: ceil(N/2).
    function automatic int unsigned hi_cnt(input int unsigned n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle between the divider and its host (enables, ratio loads, sync, divided outputs).
// Latency: n/a (wires only).
// Backpressure: none; loads are single-cycle strobes that are always accepted.
interface clk_div_multi_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*DIV_W-1:0] div_ratio;
    logic                    sync;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       pending;
    logic [NUM_CH*DIV_W-1:0] active_div;

    modport master (
        output en, load, div_ratio, sync,
        input  clk_out, tick, pending, active_div
    );

    modport slave (
        input  en, load, div_ratio, sync,
        output clk_out, tick, pending, active_div
    );
endinterface

// File: rtl/clk_div_chan.sv
// One programmable divider channel: counter, active/next ratio, divided clock and tick.
// Latency: outputs registered; first edge after enable (or sync) gives clk_out=1, tick=1.
// Backpressure: none; a load while running is held pending until the next wrap or sync.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 50
) (
    input  logic             clk_50MHz,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             sync,
    input  logic [DIV_W-1:0] ratio,
    output logic             clk_out,
    output logic             tick,
    output logic             pending,
    output logic [DIV_W-1:0] active_div
);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] RST_CNT  = DIV_W'(DEFAULT_DIV - 1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act;
    logic [DIV_W-1:0] nxt;
    logic             pend;

    logic [DIV_W-1:0] cand;
    logic [DIV_W-1:0] act_new;
    logic [DIV_W-1:0] n_cur;
    logic [DIV_W-1:0] n_new;
    logic [DIV_W-1:0] hi_cur;
    logic [DIV_W-1:0] cnt_inc;
    logic             wrap;
    logic             apply;

    // Period boundary detection and selection of the ratio that governs the next period.
    always_comb begin
        cand    = load ? ratio : nxt;
        n_cur   = DIV_W'(eff_div(32'(act)));
        hi_cur  = DIV_W'(hi_cnt(32'(n_cur)));
        cnt_inc = cnt + ONE;
        wrap    = (cnt == n_cur - ONE);
        // Boundaries where a new ratio may take effect without cutting a period short.
        apply   = !en || sync || wrap;
        act_new = (load || pend) ? cand : act;
        n_new   = DIV_W'(eff_div(32'(act_new)));
    end

    // Counter, ratio registers and registered clock/tick outputs.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            cnt     <= RST_CNT;
            act     <= RST_DIV;
            nxt     <= RST_DIV;
            pend    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (apply) begin
            act  <= act_new;
            nxt  <= cand;
            pend <= 1'b0;
            if (!en) begin
                // Parked at the last count so the first enabled edge wraps.
                cnt     <= n_new - ONE;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else begin
                cnt     <= '0;
                clk_out <= 1'b1;
                tick    <= 1'b1;
            end
        end else begin
            cnt     <= cnt_inc;
            clk_out <= (cnt_inc < hi_cur);
            tick    <= 1'b0;
            if (load) begin
                nxt  <= ratio;
                pend <= 1'b1;
            end
        end
    end

    assign pending    = pend;
    assign active_div = act;
endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider for the 50 MHz domain with shared phase sync.
// Latency: one clk_50MHz edge from enable/sync to clk_out and tick high.
// Backpressure: none; ratio loads always accepted, applied at the next period boundary.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 50
) (
    input  logic           clk_50MHz,
    input  logic           rst,
    clk_div_multi_if.slave bus
);
    logic [NUM_CH-1:0]       clk_out_w;
    logic [NUM_CH-1:0]       tick_w;
    logic [NUM_CH-1:0]       pending_w;
    logic [NUM_CH*DIV_W-1:0] active_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_50MHz  (clk_50MHz),
            .rst        (rst),
            .en         (bus.en[i]),
            .load       (bus.load[i]),
            .sync       (bus.sync),
            .ratio      (bus.div_ratio[i*DIV_W +: DIV_W]),
            .clk_out    (clk_out_w[i]),
            .tick       (tick_w[i]),
            .pending    (pending_w[i]),
            .active_div (active_w[i*DIV_W +: DIV_W])
        );
    end

    assign bus.clk_out    = clk_out_w;
    assign bus.tick       = tick_w;
    assign bus.pending    = pending_w;
    assign bus.active_div = active_w;
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi with an expected-value scoreboard queue.
// Latency: samples 1 time unit after each rising clk_50MHz edge.
// Backpressure: n/a.
module tb_clk_div_multi;
    logic clk;
    logic rst;

    clk_div_multi_if #(.NUM_CH(4), .DIV_W(8)) bus ();

    clk_div_multi #(
        .NUM_CH      (4),
        .DIV_W       (8),
        .DEFAULT_DIV (50)
    ) dut (
        .clk_50MHz (clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    logic [31:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: observed %0h, scoreboard empty", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi;
        int tk;
        int pc;

        rst           = 1'b0;
        bus.en        = '0;
        bus.load      = '0;
        bus.div_ratio = '0;
        bus.sync      = 1'b0;
        #2 rst = 1'b1;
        #3;

        // Reset state
        push_exp(32'h0); chk("rst_clk_out", 32'(bus.clk_out));
        push_exp(32'h0); chk("rst_tick", 32'(bus.tick));
        push_exp(32'h0); chk("rst_pending", 32'(bus.pending));
        push_exp(32'h32323232); chk("rst_active_div", bus.active_div);

        @(negedge clk);
        rst = 1'b0;

        // Channel 0 at default ratio 50: first edge high + tick
        bus.en = 4'b0001;
        push_exp(32'h1); push_exp(32'h1);
        step();
        chk("en0_first_clk", 32'(bus.clk_out[0]));
        chk("en0_first_tick", 32'(bus.tick[0]));

        push_exp(32'd24); push_exp(32'd0);
        hi = 0; tk = 0;
        for (int k = 0; k < 49; k++) begin
            step();
            hi += int'(bus.clk_out[0]);
            tk += int'(bus.tick[0]);
        end
        chk("div50_high_cycles", 32'(hi));
        chk("div50_mid_ticks", 32'(tk));
        push_exp(32'h1); push_exp(32'h1);
        step();
        chk("div50_wrap_tick", 32'(bus.tick[0]));
        chk("div50_wrap_clk", 32'(bus.clk_out[0]));

        // Load ratio 3 mid-period on channel 0
        for (int k = 0; k < 4; k++) step();
        bus.load = 4'b0001;
        bus.div_ratio = 32'h0000_0003;
        step();
        bus.load = 4'b0000;
        push_exp(32'h1); chk("load3_pending", 32'(bus.pending[0]));
        push_exp(32'd50); chk("load3_active_old", 32'(bus.active_div[7:0]));

        push_exp(32'd44); push_exp(32'd0); push_exp(32'd19);
        pc = 0; tk = 0; hi = 0;
        for (int k = 0; k < 44; k++) begin
            step();
            pc += int'(bus.pending[0]);
            tk += int'(bus.tick[0]);
            hi += int'(bus.clk_out[0]);
        end
        chk("load3_pending_hold", 32'(pc));
        chk("load3_no_early_tick", 32'(tk));
        chk("load3_old_period_high", 32'(hi));

        push_exp(32'h1); push_exp(32'h1); push_exp(32'h0); push_exp(32'd3);
        step();
        chk("load3_apply_tick", 32'(bus.tick[0]));
        chk("load3_apply_clk", 32'(bus.clk_out[0]));
        chk("load3_apply_pending", 32'(bus.pending[0]));
        chk("load3_apply_active", 32'(bus.active_div[7:0]));
        // New period: cnt 1 high, cnt 2 low, then wrap
        push_exp(32'h1); push_exp(32'h0); push_exp(32'h0); push_exp(32'h0); push_exp(32'h1); push_exp(32'h1);
        step(); chk("div3_c1_clk", 32'(bus.clk_out[0])); chk("div3_c1_tick", 32'(bus.tick[0]));
        step(); chk("div3_c2_clk", 32'(bus.clk_out[0])); chk("div3_c2_tick", 32'(bus.tick[0]));
        step(); chk("div3_c0_clk", 32'(bus.clk_out[0])); chk("div3_c0_tick", 32'(bus.tick[0]));

        // Ratios 1,2,0 on ch1..3 loaded while disabled
        bus.div_ratio = {8'd0, 8'd2, 8'd1, 8'd3};
        bus.load = 4'b1110;
        step();
        bus.load = 4'b0000;
        push_exp(32'h0); chk("dis_load_pending", 32'(bus.pending[3:1]));
        push_exp(32'h000201); chk("dis_load_active", 32'(bus.active_div[31:8]));

        bus.en = 4'b1111;
        push_exp(32'h7); push_exp(32'h7);
        step();
        chk("en123_first_clk", 32'(bus.clk_out[3:1]));
        chk("en123_first_tick", 32'(bus.tick[3:1]));
        for (int k = 1; k <= 4; k++) begin
            push_exp({29'd0, 1'b1, (k % 2 == 0), 1'b1});
            push_exp({29'd0, 1'b1, (k % 2 == 0), 1'b1});
            step();
            chk("small_ratio_clk", 32'(bus.clk_out[3:1]));
            chk("small_ratio_tick", 32'(bus.tick[3:1]));
        end

        // Ch0=5, ch1=7, then global sync
        bus.div_ratio = {8'd0, 8'd2, 8'd7, 8'd5};
        bus.load = 4'b0011;
        step();
        bus.load = 4'b0000;
        for (int k = 0; k < 3; k++) step();
        bus.sync = 1'b1;
        push_exp(32'h3); push_exp(32'h3); push_exp(32'h0705);
        step();
        bus.sync = 1'b0;
        chk("sync_clk", 32'(bus.clk_out[1:0]));
        chk("sync_tick", 32'(bus.tick[1:0]));
        chk("sync_active", 32'(bus.active_div[15:0]));
        for (int k = 1; k <= 14; k++) begin
            push_exp({28'd0, (k % 7 < 4), (k % 5 < 3), (k % 7 == 0), (k % 5 == 0)});
            step();
            chk("post_sync_5_7", {28'd0, bus.clk_out[1], bus.clk_out[0], bus.tick[1], bus.tick[0]});
        end

        // Pending load, then asynchronous reset mid-period
        step();
        bus.div_ratio = {8'd0, 8'd2, 8'd7, 8'd9};
        bus.load = 4'b0001;
        step();
        bus.load = 4'b0000;
        push_exp(32'h1); chk("pre_rst_pending", 32'(bus.pending[0]));
        push_exp(32'h1); chk("pre_rst_ch3_high", 32'(bus.clk_out[3]));
        #2 rst = 1'b1;
        #1;
        push_exp(32'h0); chk("async_rst_clk_out", 32'(bus.clk_out));
        push_exp(32'h0); chk("async_rst_tick", 32'(bus.tick));
        push_exp(32'h0); chk("async_rst_pending", 32'(bus.pending));
        push_exp(32'h32323232); chk("async_rst_active", bus.active_div);

        step();
        @(negedge clk);
        rst = 1'b0;
        push_exp(32'hF); push_exp(32'hF);
        step();
        chk("restart_clk", 32'(bus.clk_out));
        chk("restart_tick", 32'(bus.tick));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
